// File: rtl/logic_triplet_pkg.sv
// logic_triplet_pkg
// Shared definitions for the logic-triplet decoder.
//   LANE_OR / LANE_AND / LANE_XOR : lane positions inside an input triplet
//   ERR_CNT_W                     : width of the error counter
//   MAX_W / lane_t                : widest lane the consistency function accepts
//   lanes_consistent()            : 1 when the three lanes could have been produced
//                                   from one operand pair (b|c, b&c, b^c)
package logic_triplet_pkg;

  localparam int LANE_OR   = 0;
  localparam int LANE_AND  = 1;
  localparam int LANE_XOR  = 2;

  localparam int ERR_CNT_W = 16;

  // The check is width-agnostic: zero-extended upper bits are always
  // consistent, so callers cast their lanes up to lane_t.
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] lane_t;

  // AND may only have ones where OR has ones, and XOR must be exactly
  // the bits where OR and AND disagree.
  function automatic logic lanes_consistent(input lane_t l_or,
                                            input lane_t l_and,
                                            input lane_t l_xor);
    return ((l_and & ~l_or) == '0) && (l_xor == (l_or ^ l_and));
  endfunction

endpackage

// File: rtl/ltd_fifo.sv
// ltd_fifo
// Small synchronous FIFO holding decoded results.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count)
//   i_push     : write i_data (taken even when full if i_pop pops on the same edge)
//   i_data     : DW-bit entry to store
//   i_pop      : remove the head entry (ignored when empty)
//   o_data     : head entry, visible combinationally
//   o_count    : number of stored entries, 0..DEPTH
//   o_empty    : o_count == 0
// DEPTH must be a power of two, so the pointers wrap by simple overflow.
module ltd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 17,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [AW:0]   o_count,
  output logic          o_empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage is not reset: its content is never visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Combinational head read keeps the result visible in the same cycle the
  // count goes non-zero.
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/logic_triplet_decoder.sv
// logic_triplet_decoder
// Accepts {XOR, AND, OR} lane triplets, checks that they describe one operand
// pair, and returns the canonical pair (b = OR lane, c = AND lane) plus an
// error flag through a small output FIFO.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_trip              : [2:0][W-1:0] triplet, lane 0 = OR, 1 = AND, 2 = XOR
//   in_valid / in_ready  : input handshake
//   out_valid / out_ready: output handshake
//   out_b, out_c, out_err: FIFO head (zero while out_valid = 0)
//   err_clr              : synchronous clear of err_cnt (priority over increment)
//   err_cnt              : saturating count of inconsistent words accepted
// Optional feature: define LOGIC_TRIPLET_ERR_CNT_EN to build the error counter;
// without it err_cnt is tied to zero and err_clr is ignored.
module logic_triplet_decoder
  import logic_triplet_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0][W-1:0]    in_trip,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_b,
  output logic [W-1:0]         out_c,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int DW = 2 * W + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_L = DEPTH[AW+1:0];

  logic          r_run;
  logic          r_s1_valid;
  logic [DW-1:0] r_s1_data;

  logic          w_accept;
  logic          w_cons;
  logic [DW-1:0] w_s1_next;
  logic [DW-1:0] w_head;
  logic [AW:0]   w_count;
  logic          w_empty;
  logic [AW+1:0] w_occ;

  assign w_cons = lanes_consistent(lane_t'(in_trip[LANE_OR]),
                                   lane_t'(in_trip[LANE_AND]),
                                   lane_t'(in_trip[LANE_XOR]));

  // Entry layout: {err, c, b}.
  assign w_s1_next = {~w_cons, in_trip[LANE_AND], in_trip[LANE_OR]};

  // Words held in s1 are already committed to the FIFO, so they count
  // against its space; this keeps the unconditional s1 push lossless.
  assign w_occ    = {1'b0, w_count} + {{(AW + 1){1'b0}}, r_s1_valid};
  assign in_ready = r_run & (w_occ < DEPTH_L);
  assign w_accept = in_valid & in_ready;

  // r_run holds in_ready low during reset and for the cycle before the
  // first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= w_s1_next;
      end
    end
  end

  ltd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_s1_valid),
    .i_data  (r_s1_data),
    .i_pop   (out_valid & out_ready),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Outputs are forced to zero while empty so reset never exposes stale RAM.
  assign out_valid = ~w_empty;
  assign out_b     = w_empty ? '0   : w_head[W-1:0];
  assign out_c     = w_empty ? '0   : w_head[2*W-1:W];
  assign out_err   = w_empty ? 1'b0 : w_head[DW-1];

`ifdef LOGIC_TRIPLET_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_cons && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign err_cnt          = '0;
`endif

endmodule
